// File: rtl/mcpu_mem_ltc_resp_pkg.sv
// Shared LTC request definitions: opcode encodings, opcode classes, and stall-injection LFSR helpers.
package mcpu_mem_ltc_resp_pkg;

  localparam logic [2:0] LTC_OPC_READ         = 3'd0;
  localparam logic [2:0] LTC_OPC_WRITE        = 3'd1;
  localparam logic [2:0] LTC_OPC_READTHROUGH  = 3'd2;
  localparam logic [2:0] LTC_OPC_WRITETHROUGH = 3'd3;
  localparam logic [2:0] LTC_OPC_PREFETCH     = 3'd4;
  localparam logic [2:0] LTC_OPC_INVALIDATE   = 3'd5;

  localparam int LINE_BITS = 256;
  localparam int BE_BITS   = LINE_BITS / 8;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;  // taps 16,14,13,11

  typedef enum logic [1:0] {
    OPC_CLS_NOP,
    OPC_CLS_RD,
    OPC_CLS_WR,
    OPC_CLS_BAD
  } opc_cls_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_GAP
  } stall_st_e;

  function automatic opc_cls_e opc_class(input logic [2:0] opc);
    opc_cls_e cls;
    case (opc)
      LTC_OPC_READ, LTC_OPC_READTHROUGH:    cls = OPC_CLS_RD;
      LTC_OPC_WRITE, LTC_OPC_WRITETHROUGH:  cls = OPC_CLS_WR;
      LTC_OPC_PREFETCH, LTC_OPC_INVALIDATE: cls = OPC_CLS_NOP;
      default:                              cls = OPC_CLS_BAD;
    endcase
    return cls;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/mcpu_mem_ltc_resp_ram.sv
// 1R1W synchronous line RAM with per-byte write enables; read data registered at the read edge.
module mcpu_mem_ltc_resp_ram
  import mcpu_mem_ltc_resp_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clkrst_mem_clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [LINE_BITS-1:0] wdata_i,
  input  logic [BE_BITS-1:0]   wbe_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [LINE_BITS-1:0] rdata_o
);

  logic [LINE_BITS-1:0] mem_q [2**ADDR_BITS];
  logic [LINE_BITS-1:0] rdata_q;

  always_ff @(posedge clkrst_mem_clk) begin
    if (we_i) begin
      for (int b = 0; b < BE_BITS; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mcpu_mem_ltc_resp.sv
// LTC stand-in responder on the arb2ltc interface: line RAM, fixed-latency in-order reads, stats.
// Optional random stall injection under MCPU_MEM_LTC_RESP_STALL_INJECT_EN.
module mcpu_mem_ltc_resp
  import mcpu_mem_ltc_resp_pkg::*;
#(
  parameter int          ADDR_BITS   = 10,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] ERR_PATTERN = 32'hDEADBEEF
) (
  input  logic                 clkrst_mem_clk,
  input  logic                 clkrst_mem_rst,
  input  logic                 arb2ltc_valid,
  input  logic [2:0]           arb2ltc_opcode,
  input  logic [26:0]          arb2ltc_addr,
  input  logic [LINE_BITS-1:0] arb2ltc_wdata,
  input  logic [BE_BITS-1:0]   arb2ltc_wbe,
  output logic                 arb2ltc_stall,
  output logic [LINE_BITS-1:0] arb2ltc_rdata,
  output logic                 arb2ltc_rvalid,
  output logic                 resp_err,
  output logic [15:0]          resp_rd_cnt,
  output logic [15:0]          resp_wr_cnt
);

  logic     accept, oor, rd_acc, wr_acc;
  opc_cls_e cls;

  assign accept = arb2ltc_valid && !arb2ltc_stall;
  assign cls    = opc_class(arb2ltc_opcode);
  assign oor    = |arb2ltc_addr[26:ADDR_BITS];
  assign rd_acc = accept && (cls == OPC_CLS_RD);
  assign wr_acc = accept && (cls == OPC_CLS_WR);

  logic [LINE_BITS-1:0] ram_rdata;

  mcpu_mem_ltc_resp_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clkrst_mem_clk (clkrst_mem_clk),
    .we_i           (wr_acc && !oor),
    .waddr_i        (arb2ltc_addr[ADDR_BITS-1:0]),
    .wdata_i        (arb2ltc_wdata),
    .wbe_i          (arb2ltc_wbe),
    .re_i           (rd_acc),
    .raddr_i        (arb2ltc_addr[ADDR_BITS-1:0]),
    .rdata_o        (ram_rdata)
  );

  logic                 rd_vld_q, rd_oor_q, err_q, err_d;
  logic [15:0]          rd_cnt_q, wr_cnt_q;
  logic [LATENCY-1:0]   pipe_vld_q;
  logic [LINE_BITS-1:0] pipe_dat_q [LATENCY];
  logic [LINE_BITS-1:0] pipe_in;

  // The RAM output register is the zeroth stage; the pipe adds LATENCY more.
  assign pipe_in = rd_oor_q ? {8{ERR_PATTERN}} : ram_rdata;
  assign err_d   = err_q || (accept && ((cls == OPC_CLS_BAD) || ((rd_acc || wr_acc) && oor)));

  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      rd_vld_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_dat_q[i] <= '0;
    end else begin
      rd_vld_q <= rd_acc;
      if (rd_acc) rd_oor_q <= oor;
      err_q <= err_d;
      if (rd_acc) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_acc) wr_cnt_q <= wr_cnt_q + 16'd1;
      pipe_vld_q[0] <= rd_vld_q;
      if (rd_vld_q) pipe_dat_q[0] <= pipe_in;
      // Data only moves with a valid token so the output holds between responses.
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
    end
  end

  assign arb2ltc_rvalid = pipe_vld_q[LATENCY-1];
  assign arb2ltc_rdata  = pipe_dat_q[LATENCY-1];
  assign resp_err       = err_q;
  assign resp_rd_cnt    = rd_cnt_q;
  assign resp_wr_cnt    = wr_cnt_q;

`ifdef MCPU_MEM_LTC_RESP_STALL_INJECT_EN
  stall_st_e   st_q, st_d;
  logic [15:0] lfsr_q;
  logic [1:0]  hold_q, hold_d;

  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      st_q   <= ST_RUN;
      lfsr_q <= LFSR_SEED;
      hold_q <= 2'd0;
    end else begin
      st_q   <= st_d;
      lfsr_q <= lfsr_next(lfsr_q);
      hold_q <= hold_d;
    end
  end

  // ST_GAP forces at least one unstalled cycle between stall runs.
  always_comb begin
    st_d   = st_q;
    hold_d = hold_q;
    case (st_q)
      ST_RUN: begin
        if (lfsr_q[2:0] == 3'd0) begin
          st_d   = ST_STALL;
          hold_d = lfsr_q[4:3];
        end
      end
      ST_STALL: begin
        if (hold_q == 2'd0) st_d = ST_GAP;
        else                hold_d = hold_q - 2'd1;
      end
      ST_GAP:  st_d = ST_RUN;
      default: st_d = ST_RUN;
    endcase
  end

  assign arb2ltc_stall = (st_q == ST_STALL);
`else
  assign arb2ltc_stall = 1'b0;
`endif

endmodule

// File: tb/tb_mcpu_mem_ltc_resp.sv
// Self-checking bench for mcpu_mem_ltc_resp: directed cases plus random traffic against a line-memory model.
module tb_mcpu_mem_ltc_resp;
  import mcpu_mem_ltc_resp_pkg::*;

  localparam int AB    = 10;
  localparam int LAT   = 2;
  localparam int NLINE = 32;
  localparam logic [255:0] ERR_LINE = {8{32'hDEADBEEF}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid = 1'b0;
  logic [2:0]   opcode = '0;
  logic [26:0]  addr = '0;
  logic [255:0] wdata = '0;
  logic [31:0]  wbe = '0;
  logic         stall, rvalid, err;
  logic [255:0] rdata;
  logic [15:0]  rd_cnt, wr_cnt;

  always #5 clk = ~clk;

  mcpu_mem_ltc_resp #(.ADDR_BITS(AB), .LATENCY(LAT), .ERR_PATTERN(32'hDEADBEEF)) dut (
    .clkrst_mem_clk (clk),
    .clkrst_mem_rst (rst),
    .arb2ltc_valid  (valid),
    .arb2ltc_opcode (opcode),
    .arb2ltc_addr   (addr),
    .arb2ltc_wdata  (wdata),
    .arb2ltc_wbe    (wbe),
    .arb2ltc_stall  (stall),
    .arb2ltc_rdata  (rdata),
    .arb2ltc_rvalid (rvalid),
    .resp_err       (err),
    .resp_rd_cnt    (rd_cnt),
    .resp_wr_cnt    (wr_cnt)
  );

  typedef struct {
    int           due;
    logic [255:0] data;
  } rsp_t;

  rsp_t         exp_q[$];
  logic [255:0] mem_m [NLINE];
  logic [15:0]  rd_m, wr_m;
  logic         err_m;
  int           cyc, n_chk, n_pass, srun;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One clock: advance to the falling edge and compare everything against the model.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("rvalid", rvalid, 1'b1);
      chk("rdata", rdata, exp_q[0].data);
      exp_q.delete(0);
    end else begin
      chk("rvalid_idle", rvalid, 1'b0);
    end
    chk("rd_cnt", rd_cnt, rd_m);
    chk("wr_cnt", wr_cnt, wr_m);
    chk("resp_err", err, err_m);
    srun = stall ? srun + 1 : 0;
`ifdef MCPU_MEM_LTC_RESP_STALL_INJECT_EN
    chk("stall_run_le4", srun <= 4, 1'b1);
`else
    chk("stall_off", stall, 1'b0);
`endif
  endtask

  task automatic model_accept(input logic [2:0] op, input logic [26:0] a,
                              input logic [255:0] wd, input logic [31:0] be);
    logic oor;
    int   idx;
    rsp_t r;
    oor = |a[26:AB];
    idx = int'(a[4:0]);
    if (op == LTC_OPC_READ || op == LTC_OPC_READTHROUGH) begin
      r.due  = cyc + 1 + LAT;
      r.data = oor ? ERR_LINE : mem_m[idx];
      exp_q.push_back(r);
      rd_m = rd_m + 16'd1;
      if (oor) err_m = 1'b1;
    end else if (op == LTC_OPC_WRITE || op == LTC_OPC_WRITETHROUGH) begin
      if (oor) err_m = 1'b1;
      else
        for (int b = 0; b < 32; b++)
          if (be[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
      wr_m = wr_m + 16'd1;
    end else if (op != LTC_OPC_PREFETCH && op != LTC_OPC_INVALIDATE) begin
      err_m = 1'b1;
    end
  endtask

  // Present a request, hold it while stalled, and leave after the accepting edge.
  task automatic req(input logic [2:0] op, input logic [26:0] a,
                     input logic [255:0] wd, input logic [31:0] be);
    int w;
    w = 0;
    valid = 1'b1; opcode = op; addr = a; wdata = wd; wbe = be;
    while (stall && w <= 20) begin
      cycle();
      w++;
    end
    chk("stall_bounded", w <= 20, 1'b1);
    model_accept(op, a, wd, be);
    cycle();
    valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    valid = 1'b0;
    exp_q.delete();
    rd_m = '0; wr_m = '0; err_m = 1'b0; srun = 0;
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, '0);
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [2:0]  op;
    logic [26:0] a;
    cyc = 0; n_chk = 0; n_pass = 0; srun = 0;
    #2;
    do_reset(3);
    repeat (10) cycle();

    req(LTC_OPC_WRITE, 27'h10, {8{32'h12345678}}, 32'hFFFFFFFF);
    req(LTC_OPC_READ, 27'h10, '0, '0);
    repeat (LAT + 3) cycle();
    chk("wr_cnt_one", wr_cnt, 16'd1);
    chk("rd_cnt_one", rd_cnt, 16'd1);
    chk("wr_rd_data", rdata, {8{32'h12345678}});

    req(LTC_OPC_WRITE, 27'h20, {256{1'b1}}, 32'hFFFFFFFF);
    req(LTC_OPC_WRITE, 27'h20, '0, 32'h0000000F);
    req(LTC_OPC_READ, 27'h20, '0, '0);
    repeat (LAT + 3) cycle();
    chk("be_rdata", rdata, {{224{1'b1}}, 32'h0});

    for (int i = 1; i <= 4; i++) req(LTC_OPC_WRITE, 27'(i), 256'(i), 32'hFFFFFFFF);
    for (int i = 1; i <= 4; i++) req(LTC_OPC_READTHROUGH, 27'(i), '0, '0);
    repeat (LAT + 3) cycle();

    req(LTC_OPC_WRITE, 27'h0, {8{32'hA5A50000}}, 32'hFFFFFFFF);
    req(LTC_OPC_READ, 27'h400000, '0, '0);
    repeat (LAT + 3) cycle();
    chk("oor_rdata", rdata, ERR_LINE);
    chk("oor_err", err, 1'b1);
    req(LTC_OPC_WRITETHROUGH, 27'h400000, '0, 32'hFFFFFFFF);
    req(LTC_OPC_READ, 27'h0, '0, '0);
    repeat (LAT + 3) cycle();
    chk("line0_kept", rdata, {8{32'hA5A50000}});
    chk("err_sticky", err, 1'b1);

    for (int i = 0; i < NLINE; i++) req(LTC_OPC_WRITE, 27'(i), rnd_line(), 32'hFFFFFFFF);

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) cycle();
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) < 5) op = {2'b00, op[0]};
      a = 27'($urandom_range(0, NLINE - 1));
      if ($urandom_range(0, 15) == 0) a[$urandom_range(AB, 26)] = 1'b1;
      req(op, a, rnd_line(), $urandom);
    end
    repeat (LAT + 3) cycle();

    for (int i = 0; i < 5; i++) req(LTC_OPC_READ, 27'(i), '0, '0);
    do_reset(2);
    repeat (LAT + 4) cycle();

    req(LTC_OPC_PREFETCH, 27'h3, '0, '0);
    req(LTC_OPC_INVALIDATE, 27'h3, '0, '0);
    repeat (2) cycle();
    chk("nop_no_err", err, 1'b0);
    req(3'd7, 27'h3, '0, '0);
    repeat (2) cycle();
    chk("bad_opc_err", err, 1'b1);
    req(LTC_OPC_READ, 27'h2, '0, '0);
    repeat (LAT + 3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
